// File: rtl/riscv_pkg.sv
// Shared fetch types and constants.
//   fetch_entry_t : one decoded-side fetch record {pc, instr, fault}
//   FETCH_STEP    : byte distance between sequential instruction words
package riscv;

   localparam int unsigned XLEN       = 32;
   localparam logic [31:0] FETCH_STEP = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetch entries with a registered head.
// Ports: push_i/data_i enqueue, pop_i dequeues, flush_i empties (wins over push/pop),
//        full_o/empty_o/count_o occupancy, head_o oldest entry (zero when empty).
// Caller guarantees no push on a full queue unless a pop happens in the same cycle.
module fetch_queue
   import riscv::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  fetch_entry_t             data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output fetch_entry_t             head_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_q];

   assign do_push = push_i & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage feeding the decoder.
// Ports: clk/reset_n; imem_req_o/imem_addr_o/imem_gnt_i request port;
//        imem_rvalid_i/imem_rdata_i/imem_err_i in-order responses;
//        redirect_i/redirect_pc_i flush-and-restart; instr_valid_o/instr_o/pc_o/
//        instr_fault_o/instr_ready_i stream to decode.
// Optional: define IFETCH_BYPASS_EN to pass a response straight to decode when the
// queue is empty and decode is ready.
module ifetch_unit
   import riscv::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_err_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        instr_fault_o,
   input  logic        instr_ready_i
);

   localparam int unsigned AW = $clog2(QUEUE_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = CW + 1;

   typedef enum logic {S_RUN, S_FLUSH} state_e;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] disc_q, disc_d;
   logic          req_q, req_d;
   logic [CW-1:0] q_count, q_count_d;

   // Addresses of requests in flight, oldest first; one pops per response.
   logic [31:0]   pcq_q [QUEUE_DEPTH];
   logic [AW-1:0] pcq_wr_q, pcq_rd_q;

   logic          gnt, rsp_keep, bypass_c;
   logic          q_push, q_pop, q_full, q_empty;
   logic [31:0]   redirect_pc_c;
   fetch_entry_t  rsp_entry, q_head, out_entry;

   assign gnt           = req_q & imem_gnt_i;
   assign redirect_pc_c = redirect_pc_i & ~32'h3;
   assign rsp_keep      = imem_rvalid_i & (disc_q == '0) & ~redirect_i;

   always_comb begin
      rsp_entry       = '0;
      rsp_entry.pc    = pcq_q[pcq_rd_q];
      rsp_entry.instr = imem_err_i ? 32'h0 : imem_rdata_i;
      rsp_entry.fault = imem_err_i;
   end

`ifdef IFETCH_BYPASS_EN
   assign bypass_c = rsp_keep & q_empty & instr_ready_i;
`else
   assign bypass_c = 1'b0;
`endif

   // Credit rule keeps the queue from overflowing; the full check covers push+pop.
   assign q_push = rsp_keep & ~bypass_c & (~q_full | q_pop);
   assign q_pop  = ~q_empty & instr_ready_i & ~redirect_i;

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (q_push),
      .data_i  (rsp_entry),
      .pop_i   (q_pop),
      .flush_i (redirect_i),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count),
      .head_o  (q_head)
   );

   assign out_entry     = bypass_c ? rsp_entry : q_head;
   assign instr_valid_o = ~q_empty | bypass_c;
   assign instr_o       = out_entry.instr;
   assign pc_o          = out_entry.pc;
   assign instr_fault_o = out_entry.fault;
   assign imem_req_o    = req_q;
   assign imem_addr_o   = fetch_pc_q;

   // Next-state: counters, PC, FSM and the registered request.
   always_comb begin
      outst_d    = outst_q + CW'(gnt) - CW'(imem_rvalid_i);
      disc_d     = disc_q;
      q_count_d  = q_count + CW'(q_push) - CW'(q_pop);
      fetch_pc_d = fetch_pc_q;
      state_d    = state_q;
      if (gnt) fetch_pc_d = fetch_pc_q + FETCH_STEP;
      if (imem_rvalid_i && (disc_q != '0)) disc_d = disc_q - CW'(1);
      // Everything still in flight after this edge, including a same-cycle grant, is stale.
      if (redirect_i) begin
         fetch_pc_d = redirect_pc_c;
         disc_d     = outst_d;
         q_count_d  = '0;
      end
      unique case (state_q)
         S_RUN:   if (redirect_i && (outst_d != '0)) state_d = S_FLUSH;
         S_FLUSH: if (disc_d == '0) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
      req_d = (state_d == S_RUN) &&
              ((SW'(outst_d) + SW'(q_count_d)) < SW'(QUEUE_DEPTH));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_RUN;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         disc_q     <= '0;
         req_q      <= 1'b0;
         pcq_wr_q   <= '0;
         pcq_rd_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         disc_q     <= disc_d;
         req_q      <= req_d;
         if (gnt)           pcq_wr_q <= pcq_wr_q + AW'(1);
         if (imem_rvalid_i) pcq_rd_q <= pcq_rd_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (gnt) pcq_q[pcq_wr_q] <= fetch_pc_q;
   end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
   import riscv::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        imem_err_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_fault_o;
   logic        instr_ready_i;

   always #5 clk = ~clk;

   ifetch_unit #(.RESET_PC(32'h100), .QUEUE_DEPTH(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .imem_err_i    (imem_err_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .instr_fault_o (instr_fault_o),
      .instr_ready_i (instr_ready_i)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: requests in flight (stale after a redirect) and the
   // in-order list of entries decode should see.
   typedef struct { logic [31:0] addr; bit stale; } req_t;
   req_t         inflight[$];
   fetch_entry_t dq[$];
   logic [31:0]  exp_pc;
   int           cyc;
   int           p_gnt, p_rv, p_rdy, p_redir;
   int           first_gnt, first_val;
   bit           saw_fault40;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit redir, input logic [31:0] rpc);
      fetch_entry_t hd;
      req_t         r;
      bit           hv, byp, live, flushing, exp_req;
      @(posedge clk);
      #1;
      imem_gnt_i    = ($urandom_range(99) < p_gnt);
      imem_rvalid_i = (inflight.size() != 0) && ($urandom_range(99) < p_rv);
      if (imem_rvalid_i) begin
         imem_rdata_i = mem_word(inflight[0].addr);
         imem_err_i   = (inflight[0].addr == 32'h40) || ($urandom_range(31) == 0);
      end else begin
         imem_rdata_i = $urandom;
         imem_err_i   = 1'($urandom_range(1));
      end
      instr_ready_i = ($urandom_range(99) < p_rdy);
      redirect_i    = redir || ($urandom_range(999) < p_redir);
      if (redir) redirect_pc_i = rpc;
      else if ($urandom_range(3) == 0) redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else redirect_pc_i = $urandom;
      @(negedge clk);
      cyc++;

      flushing = 1'b0;
      foreach (inflight[i]) if (inflight[i].stale) flushing = 1'b1;
      exp_req = !flushing && ((inflight.size() + dq.size()) < 4);
      live    = imem_rvalid_i && !inflight[0].stale && !redirect_i;
      hv  = (dq.size() != 0);
      byp = 1'b0;
      hd  = '0;
      if (hv) hd = dq[0];
`ifdef IFETCH_BYPASS_EN
      if (!hv && live && instr_ready_i) begin
         hv  = 1'b1;
         byp = 1'b1;
         hd  = '{pc: inflight[0].addr, instr: imem_err_i ? 32'h0 : mem_word(inflight[0].addr),
                 fault: imem_err_i};
      end
`endif
      chk("req", 32'(imem_req_o), 32'(exp_req));
      chk("valid", 32'(instr_valid_o), 32'(hv));
      if (hv) begin
         chk("pc", pc_o, hd.pc);
         chk("instr", instr_o, hd.instr);
         chk("fault", 32'(instr_fault_o), 32'(hd.fault));
      end
      if (imem_req_o && imem_gnt_i && first_gnt < 0) first_gnt = cyc;
      if (instr_valid_o && first_val < 0) first_val = cyc;

      // Consume head, then response, then grant, then redirect.
      if (hv && instr_ready_i && !redirect_i) begin
         if (hd.pc == 32'h40 && hd.fault) saw_fault40 = 1'b1;
         if (!byp) void'(dq.pop_front());
      end
      if (imem_rvalid_i) begin
         r = inflight.pop_front();
         if (live && !byp)
            dq.push_back('{pc: r.addr, instr: imem_err_i ? 32'h0 : mem_word(r.addr),
                           fault: imem_err_i});
      end
      if (imem_req_o && imem_gnt_i) begin
         chk("addr", imem_addr_o, exp_pc);
         inflight.push_back('{addr: exp_pc, stale: redirect_i});
         exp_pc = exp_pc + 32'd4;
      end
      if (redirect_i) begin
         dq.delete();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         exp_pc = redirect_pc_i & ~32'h3;
      end
   endtask

   task automatic knobs(input int g, input int rv, input int rdy, input int rd);
      p_gnt = g; p_rv = rv; p_rdy = rdy; p_redir = rd;
   endtask

   initial begin
      reset_n = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      imem_err_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
      exp_pc = 32'h100; cyc = 0; first_gnt = -1; first_val = -1; saw_fault40 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_addr", imem_addr_o, 32'h100);
      chk("rst_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_fault", 32'(instr_fault_o), 32'd0);
      reset_n = 1'b1;

      // Streaming with an always-granting, one-cycle memory.
      knobs(100, 100, 100, 0);
      repeat (12) step(1'b0, '0);
`ifdef IFETCH_BYPASS_EN
      chk("first_latency", 32'(first_val - first_gnt), 32'd1);
`else
      chk("first_latency", 32'(first_val - first_gnt), 32'd2);
`endif

      // Backpressure then drain.
      knobs(100, 100, 0, 0);
      repeat (10) step(1'b0, '0);
      chk("bp_req_low", 32'(imem_req_o), 32'd0);
      chk("bp_valid", 32'(instr_valid_o), 32'd1);
      knobs(100, 100, 100, 0);
      repeat (8) step(1'b0, '0);

      // Redirect with exactly two requests in flight.
      knobs(0, 100, 100, 0);
      repeat (6) step(1'b0, '0);
      knobs(100, 0, 100, 0);
      repeat (2) step(1'b0, '0);
      knobs(0, 0, 100, 0);
      step(1'b1, 32'h2002);
      knobs(100, 100, 100, 0);
      repeat (10) step(1'b0, '0);

      // Redirect, grant and response in the same cycle.
      step(1'b1, 32'h3000);
      repeat (8) step(1'b0, '0);

      // Access fault at 0x40, then wrap at the top of the address space.
      step(1'b1, 32'h40);
      repeat (8) step(1'b0, '0);
      chk("fault40_seen", 32'(saw_fault40), 32'd1);
      step(1'b1, 32'hFFFF_FFFC);
      repeat (8) step(1'b0, '0);

      // Randomised traffic.
      knobs(70, 60, 70, 30);
      repeat (3000) step(1'b0, '0);

      // Reset in the middle of traffic.
      @(negedge clk);
      reset_n = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0;
      #1;
      chk("mid_rst_req", 32'(imem_req_o), 32'd0);
      chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
      chk("mid_rst_addr", imem_addr_o, 32'h100);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      inflight.delete(); dq.delete(); exp_pc = 32'h100;
      knobs(100, 100, 100, 0);
      repeat (12) step(1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
